// File: rtl/key_input_pkg.sv
// rtl/key_input_pkg.sv - key index map, debounce FSM encoding and counter sizing helpers
package key_input_pkg;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;

    localparam int KEY_DEBOUNCE_DEF = 500_000;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_PEND = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_REL_PEND   = 2'd3
    } key_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one key: 2-FF sync, debounce FSM, press pulse register
// KEY_REPEAT_EN adds an auto-repeat counter while the key stays in PRESSED.
module key_debounce
    import key_input_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = KEY_DEBOUNCE_DEF,
    parameter int KEY_ACTIVE_LOW   = 1,
    parameter int REPEAT_DELAY_CYC = 12_500_000,
    parameter int REPEAT_RATE_CYC  = 2_500_000
) (
    input  logic vga_clk,
    input  logic sys_rst_n,
    input  logic key_raw,
    output logic key_fire,
    output logic key_pulse,
    output logic key_held
);

    localparam int CNT_W = cnt_width(max3(DEBOUNCE_CYC, REPEAT_DELAY_CYC, REPEAT_RATE_CYC));
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic             raw_norm;
    logic [1:0]       sync_ff;
    logic             key_sync;
    key_state_t       state, next_state;
    logic [CNT_W-1:0] deb_cnt;
    logic             held_q;
    logic             rep_fire;

    assign raw_norm = (KEY_ACTIVE_LOW != 0) ? ~key_raw : key_raw;
    assign key_sync = sync_ff[1];

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], raw_norm};
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:       if (key_sync) next_state = ST_PRESS_PEND;
            ST_PRESS_PEND: begin
                if (!key_sync)               next_state = ST_IDLE;
                else if (deb_cnt == DEB_LAST) next_state = ST_PRESSED;
            end
            ST_PRESSED:    if (!key_sync) next_state = ST_REL_PEND;
            ST_REL_PEND: begin
                if (key_sync)                next_state = ST_PRESSED;
                else if (deb_cnt == DEB_LAST) next_state = ST_IDLE;
            end
            default:       next_state = ST_IDLE;
        endcase
    end

    // The count only survives while sync agrees with the level being confirmed.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            deb_cnt <= '0;
        end else begin
            case (state)
                ST_PRESS_PEND: deb_cnt <= !key_sync ? '0 : (deb_cnt != CNT_MAX) ? deb_cnt + 1'b1 : deb_cnt;
                ST_REL_PEND:   deb_cnt <=  key_sync ? '0 : (deb_cnt != CNT_MAX) ? deb_cnt + 1'b1 : deb_cnt;
                default:       deb_cnt <= '0;
            endcase
        end
    end

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_DELAY  = CNT_W'(REPEAT_DELAY_CYC);
    localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_DELAY_CYC - REPEAT_RATE_CYC + 1);

    logic [CNT_W-1:0] rep_cnt;

    // REL_PEND freezes the count so a short release glitch does not restart the repeat delay.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rep_cnt <= '0;
        end else if (state == ST_PRESSED) begin
            if (rep_cnt == REP_DELAY)    rep_cnt <= REP_RELOAD;
            else if (rep_cnt != CNT_MAX) rep_cnt <= rep_cnt + 1'b1;
        end else if (state != ST_REL_PEND) begin
            rep_cnt <= '0;
        end
    end

    assign rep_fire = (state == ST_PRESSED) && (rep_cnt == REP_DELAY);
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            held_q    <= 1'b0;
            key_pulse <= 1'b0;
        end else begin
            held_q    <= key_held;
            key_pulse <= key_fire;
        end
    end

    // First cycle of PRESSED coming from PRESS_PEND; a return from REL_PEND has held_q set.
    always_comb begin
        key_held = (state == ST_PRESSED) || (state == ST_REL_PEND);
        key_fire = ((state == ST_PRESSED) && !held_q) || rep_fire;
    end

endmodule

// File: rtl/key_input.sv
// rtl/key_input.sv - four debounced push-buttons to single-cycle key events
// KEY_REPEAT_EN (in key_debounce) enables auto-repeat on held keys.
module key_input
    import key_input_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = KEY_DEBOUNCE_DEF,
    parameter int KEY_ACTIVE_LOW   = 1,
    parameter int REPEAT_DELAY_CYC = 12_500_000,
    parameter int REPEAT_RATE_CYC  = 2_500_000
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] key_raw,
    output logic       key_up,
    output logic       key_down,
    output logic       key_left,
    output logic       key_right,
    output logic       key_press,
    output logic [3:0] key_held
);

    logic [3:0] key_fire;
    logic [3:0] key_pulse;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYC     (DEBOUNCE_CYC),
            .KEY_ACTIVE_LOW   (KEY_ACTIVE_LOW),
            .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
            .REPEAT_RATE_CYC  (REPEAT_RATE_CYC)
        ) u_key (
            .vga_clk   (vga_clk),
            .sys_rst_n (sys_rst_n),
            .key_raw   (key_raw[i]),
            .key_fire  (key_fire[i]),
            .key_pulse (key_pulse[i]),
            .key_held  (key_held[i])
        );
    end

    // Registered from the same fire terms as the per-key pulses, so it lines up with them.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_press <= 1'b0;
        end else begin
            key_press <= |key_fire;
        end
    end

    assign key_up    = key_pulse[KEY_UP];
    assign key_down  = key_pulse[KEY_DOWN];
    assign key_left  = key_pulse[KEY_LEFT];
    assign key_right = key_pulse[KEY_RIGHT];

endmodule
